// File: rtl/snf_pcrd_sched.sv
// snf_pcrd_sched: P-credit scheduler tracking free tracker entries and owed credits and issuing PCrdGrant offers
// SNF_PCRD_STATIC_PRIO_EN selects lowest-index pick instead of round-robin
module snf_pcrd_sched #(
  parameter int SRC_NUM       = 4,
  parameter int SRC_IDX_WIDTH = 2,
  parameter int TRK_NUM       = 16,
  parameter int TRK_CNT_WIDTH = 5,
  parameter int OWE_CNT_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run_state,
  input  logic                     rxreq_valid_s0,
  input  logic                     rxreq_allowretry_s0,
  input  logic [SRC_IDX_WIDTH-1:0] rxreq_srcidx_s0,
  input  logic                     trk_release_s1,
  input  logic                     txrsp_pcrdgrant_won_s1,
  output logic                     rxreq_retry_enable_s0,
  output logic                     pcrdgrant_valid,
  output logic [SRC_IDX_WIDTH-1:0] pcrdgrant_srcidx,
  output logic                     pcrd_owe_ovf
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t                   state;
  logic [TRK_CNT_WIDTH-1:0] free_cnt, reserved_cnt, avail;
  logic [OWE_CNT_WIDTH-1:0] owe_cnt [SRC_NUM];
  logic [SRC_NUM-1:0]       owe_nz;
  logic [SRC_IDX_WIDTH-1:0] pick;
  logic                     any_owe, retry, alloc, won, rsv_dec, same_src;
  for (genvar i = 0; i < SRC_NUM; i++) begin : g_nz
    assign owe_nz[i] = owe_cnt[i] != '0;
  end
  assign avail                 = free_cnt - reserved_cnt;
  assign any_owe               = |owe_nz;
  assign retry                 = rxreq_valid_s0 & rxreq_allowretry_s0 & ((avail == '0) | any_owe);
  assign rxreq_retry_enable_s0 = retry;
  assign alloc                 = rxreq_valid_s0 & ~retry;
  assign won                   = (state == OFFER) & txrsp_pcrdgrant_won_s1;
  assign rsv_dec               = alloc & ~rxreq_allowretry_s0 & (reserved_cnt != '0);
  assign same_src              = won & (pcrdgrant_srcidx == rxreq_srcidx_s0);
`ifdef SNF_PCRD_STATIC_PRIO_EN
  always_comb begin
    pick = '0;
    for (int i = SRC_NUM - 1; i >= 0; i--)
      if (owe_nz[i]) pick = SRC_IDX_WIDTH'(i);
  end
`else
  logic [SRC_IDX_WIDTH-1:0] rr_ptr, idx;
  // scan downwards so the entry closest to rr_ptr is the last, winning assignment
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int k = SRC_NUM - 1; k >= 0; k--) begin
      idx = SRC_IDX_WIDTH'((int'(rr_ptr) + k) % SRC_NUM);
      if (owe_nz[idx]) pick = idx;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr <= '0;
    else if (won) rr_ptr <= (pcrdgrant_srcidx == SRC_IDX_WIDTH'(SRC_NUM - 1)) ? '0 : pcrdgrant_srcidx + 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      free_cnt     <= TRK_CNT_WIDTH'(TRK_NUM);
      reserved_cnt <= '0;
    end else begin
      if (alloc & ~trk_release_s1 & (free_cnt != '0)) free_cnt <= free_cnt - 1'b1;
      else if (trk_release_s1 & ~alloc & (free_cnt != TRK_CNT_WIDTH'(TRK_NUM))) free_cnt <= free_cnt + 1'b1;
      reserved_cnt <= reserved_cnt + TRK_CNT_WIDTH'(won) - TRK_CNT_WIDTH'(rsv_dec);
    end
  // a retry and a grant on the same source cancel out
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < SRC_NUM; i++) owe_cnt[i] <= '0;
      pcrd_owe_ovf <= 1'b0;
    end else begin
      for (int i = 0; i < SRC_NUM; i++) begin
        if (retry & (rxreq_srcidx_s0 == SRC_IDX_WIDTH'(i)) & ~same_src)
          owe_cnt[i] <= (&owe_cnt[i]) ? owe_cnt[i] : owe_cnt[i] + 1'b1;
        else if (won & (pcrdgrant_srcidx == SRC_IDX_WIDTH'(i)) & ~(retry & same_src))
          owe_cnt[i] <= owe_cnt[i] - 1'b1;
      end
      if (retry & (&owe_cnt[rxreq_srcidx_s0]) & ~same_src) pcrd_owe_ovf <= 1'b1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state            <= IDLE;
      pcrdgrant_valid  <= 1'b0;
      pcrdgrant_srcidx <= '0;
    end else if (state == IDLE) begin
      if (run_state & any_owe & (avail != '0)) begin
        state            <= OFFER;
        pcrdgrant_valid  <= 1'b1;
        pcrdgrant_srcidx <= pick;
      end
    end else if (txrsp_pcrdgrant_won_s1) begin
      state           <= IDLE;
      pcrdgrant_valid <= 1'b0;
    end
endmodule

// File: tb/tb_snf_pcrd_sched.sv
// tb_snf_pcrd_sched: scoreboard bench for snf_pcrd_sched; expected grant targets are queued ahead of offers
module tb_snf_pcrd_sched;
  localparam int SW = 2;
  logic          clk = 1'b0, rst_n = 1'b0, run_state = 1'b1;
  logic          v = 1'b0, ar = 1'b0, rel = 1'b0, won = 1'b0;
  logic [SW-1:0] src = '0;
  logic          retry, gv, ovf;
  logic [SW-1:0] gsrc;
  int            n_vec = 0, n_mis = 0;
  int            exp_q[$];
  snf_pcrd_sched dut (
    .clk(clk), .rst_n(rst_n), .run_state(run_state),
    .rxreq_valid_s0(v), .rxreq_allowretry_s0(ar), .rxreq_srcidx_s0(src),
    .trk_release_s1(rel), .txrsp_pcrdgrant_won_s1(won),
    .rxreq_retry_enable_s0(retry), .pcrdgrant_valid(gv),
    .pcrdgrant_srcidx(gsrc), .pcrd_owe_ovf(ovf)
  );
  always #5 clk = ~clk;
  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task step(input logic iv, input logic iar, input int isrc, input logic irel, input logic iwon);
    @(negedge clk);
    v = iv; ar = iar; src = isrc[SW-1:0]; rel = irel; won = iwon;
    #1;
  endtask
  task idle();
    step(0, 0, 0, 0, 0);
  endtask
  task rel1();
    step(0, 0, 0, 1, 0);
  endtask
  task req(input logic iar, input int isrc, input logic exp_retry);
    step(1, iar, isrc, 0, 0);
    check("retry", {31'd0, retry}, {31'd0, exp_retry});
  endtask
  task grant();
    int t, e;
    t = 0;
    while (!gv && t < 20) begin
      idle();
      t++;
    end
    check("offer_timeout", {31'd0, gv}, 1);
    e = exp_q.size() != 0 ? exp_q.pop_front() : -1;
    if (gv) begin
      check("grant_src", {30'd0, gsrc}, e);
      step(0, 0, 0, 0, 1);
      idle();
      check("valid_drop", {31'd0, gv}, 0);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", {31'd0, gv}, 0);
    check("rst_ovf", {31'd0, ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) req(1, i % 4, 0);
    req(1, 2, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1);
      check("no_offer_avail0", {31'd0, gv}, 0);
    end
    rel1();
    check("offer_latency0", {31'd0, gv}, 0);
    idle();
    check("offer_latency1", {31'd0, gv}, 0);
    idle();
    check("offer_valid", {31'd0, gv}, 1);
    check("offer_src", {30'd0, gsrc}, 2);
    idle();
    check("offer_hold", {31'd0, gv}, 1);
    exp_q.push_back(2);
    grant();
    req(0, 1, 0);
    rel1();
    req(1, 1, 0);
    req(1, 0, 1);
    rel1();
    exp_q.push_back(0);
    grant();
    req(0, 2, 0);
    req(1, 1, 1);
    req(1, 3, 1);
    req(1, 0, 1);
    run_state = 1'b0;
    repeat (3) rel1();
    for (int i = 0; i < 3; i++) begin
      idle();
      check("no_offer_stopped", {31'd0, gv}, 0);
    end
    run_state = 1'b1;
`ifdef SNF_PCRD_STATIC_PRIO_EN
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
`else
    exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(0);
`endif
    repeat (3) grant();
    repeat (3) req(0, 1, 0);
    for (int i = 0; i < 15; i++) req(1, 0, 1);
    idle();
    check("ovf_at_15", {31'd0, ovf}, 0);
    req(1, 0, 1);
    idle();
    check("ovf_set", {31'd0, ovf}, 1);
    rel1();
    for (int t = 0; t < 20 && !gv; t++) idle();
    check("ovf_offer", {31'd0, gv}, 1);
    check("ovf_offer_src", {30'd0, gsrc}, 0);
    @(negedge clk);
    rst_n = 1'b0; v = 1'b1; ar = 1'b1; src = '0;
    #1;
    check("midrst_valid", {31'd0, gv}, 0);
    check("midrst_ovf", {31'd0, ovf}, 0);
    check("midrst_retry", {31'd0, retry}, 0);
    @(negedge clk);
    rst_n = 1'b1; v = 1'b0; ar = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      check("post_rst_no_offer", {31'd0, gv}, 0);
    end
    req(1, 3, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
